// File: rtl/pal_cfg_pkg.sv
// Shared state encoding and sizing helpers for the PAL configuration serializer.
package pal_cfg_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_APPLY    = 3'd4;

    // Total configuration bits: two literals per input per product term plus the OR plane.
    function automatic int unsigned pal_cfg_bits(input int unsigned n,
                                                 input int unsigned m,
                                                 input int unsigned p);
        return 2 * n * p + m * p;
    endfunction

    // Bytes the source must supply for a given bit count.
    function automatic int unsigned pal_cfg_bytes(input int unsigned bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/pal_cfg_phase_cnt.sv
// Half-period counter: counts cycles spent in the current FSM state, saturating at CLK_DIV-1.
module pal_cfg_phase_cnt #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic res_n,
    input  logic clr_c,
    output logic tc_c
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_c = (cnt_q == CW'(CLK_DIV - 1));

    // Restart on state entry, otherwise advance until terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_c) begin
            cnt_d = '0;
        end else if (!tc_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pal_cfg_serializer.sv
// Byte stream to PAL serial configuration: shifts CFG_BITS bits LSB first, then raises cfg_en.
module pal_cfg_serializer
    import pal_cfg_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 7,
    parameter int unsigned P        = 32,
    parameter int unsigned CFG_BITS = pal_cfg_bits(N, M, P),
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       cfg_bit,
    output logic       cfg_sclk,
    output logic       cfg_en,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BSW = $clog2(CFG_BITS + 1);

    logic [2:0]     state_q,     state_d;
    logic [7:0]     buf_q,       buf_d;
    logic [2:0]     bit_idx_q,   bit_idx_d;
    logic [BSW-1:0] bits_sent_q, bits_sent_d;
    logic           s_ready_q,   s_ready_d;
    logic           cfg_bit_q,   cfg_bit_d;
    logic           cfg_sclk_q,  cfg_sclk_d;
    logic           cfg_en_q,    cfg_en_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic           phase_clr_c;
    logic           phase_tc_c;

    assign s_ready  = s_ready_q;
    assign cfg_bit  = cfg_bit_q;
    assign cfg_sclk = cfg_sclk_q;
    assign cfg_en   = cfg_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Phase counter restarts whenever the FSM moves to a different state.
    assign phase_clr_c = (state_d != state_q);

    pal_cfg_phase_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_cnt (
        .clk   (clk),
        .res_n (res_n),
        .clr_c (phase_clr_c),
        .tc_c  (phase_tc_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        bit_idx_d   = bit_idx_q;
        bits_sent_d = bits_sent_q;
        cfg_bit_d   = cfg_bit_q;
        cfg_en_d    = cfg_en_q;

        if (abort) begin
            state_d     = ST_IDLE;
            cfg_bit_d   = 1'b0;
            cfg_en_d    = 1'b0;
            bit_idx_d   = '0;
            bits_sent_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_FETCH;
                        cfg_en_d    = 1'b0;
                        bits_sent_d = '0;
                    end
                end
                ST_FETCH: begin
                    if (s_valid && s_ready_q) begin
                        buf_d     = s_data;
                        bit_idx_d = '0;
                        cfg_bit_d = s_data[0];
                        state_d   = ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_tc_c) begin
                        state_d = ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_tc_c) begin
                        bits_sent_d = bits_sent_q + BSW'(1);
                        bit_idx_d   = bit_idx_q + 3'd1;
                        buf_d       = buf_q >> 1;
                        if (bits_sent_q == BSW'(CFG_BITS - 1)) begin
                            state_d   = ST_APPLY;
                            cfg_bit_d = 1'b0;
                            cfg_en_d  = 1'b1;
                        end else if (bit_idx_q == 3'd7) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d   = ST_SHIFT_LO;
                            cfg_bit_d = buf_q[1];
                        end
                    end
                end
                ST_APPLY: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        s_ready_d  = (state_d == ST_FETCH);
        cfg_sclk_d = (state_d == ST_SHIFT_HI);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_APPLY);
    end

    // State and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            bit_idx_q   <= '0;
            bits_sent_q <= '0;
            s_ready_q   <= 1'b0;
            cfg_bit_q   <= 1'b0;
            cfg_sclk_q  <= 1'b0;
            cfg_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            bit_idx_q   <= bit_idx_d;
            bits_sent_q <= bits_sent_d;
            s_ready_q   <= s_ready_d;
            cfg_bit_q   <= cfg_bit_d;
            cfg_sclk_q  <= cfg_sclk_d;
            cfg_en_q    <= cfg_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pal_cfg_serializer.sv
// Directed bench: a 736-bit instance and a 12-bit instance sharing clock and reset.
module tb_pal_cfg_serializer;

    logic       clk = 1'b0;
    logic       res_n;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic [7:0] s_data;
    logic       sel;

    logic r0, b0, k0, e0, y0, d0;
    logic r1, b1, k1, e1, y1, d1;
    logic o_ready, o_bit, o_sclk, o_en, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:95];

    always #5 clk = ~clk;

    pal_cfg_serializer #(.CLK_DIV(2)) u_big (
        .clk      (clk),
        .res_n    (res_n),
        .start    (start & ~sel),
        .abort    (abort & ~sel),
        .s_data   (s_data),
        .s_valid  (s_valid & ~sel),
        .s_ready  (r0),
        .cfg_bit  (b0),
        .cfg_sclk (k0),
        .cfg_en   (e0),
        .busy     (y0),
        .done     (d0)
    );

    pal_cfg_serializer #(.CFG_BITS(12), .CLK_DIV(2)) u_small (
        .clk      (clk),
        .res_n    (res_n),
        .start    (start & sel),
        .abort    (abort & sel),
        .s_data   (s_data),
        .s_valid  (s_valid & sel),
        .s_ready  (r1),
        .cfg_bit  (b1),
        .cfg_sclk (k1),
        .cfg_en   (e1),
        .busy     (y1),
        .done     (d1)
    );

    assign o_ready = sel ? r1 : r0;
    assign o_bit   = sel ? b1 : b0;
    assign o_sclk  = sel ? k1 : k0;
    assign o_en    = sel ? e1 : e0;
    assign o_busy  = sel ? y1 : y0;
    assign o_done  = sel ? d1 : d0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, int'(o_ready), 0);
        check({tag, "_bit"},   int'(o_bit),   0);
        check({tag, "_sclk"},  int'(o_sclk),  0);
        check({tag, "_en"},    int'(o_en),    0);
        check({tag, "_busy"},  int'(o_busy),  0);
        check({tag, "_done"},  int'(o_done),  0);
    endtask

    // One load session with optional source stall, abort, or start-while-busy injection.
    task automatic run_load(input int nbits, input int nbytes, input int stall_byte,
                            input int stall_len, input int abort_bits, input int start_bits);
        int   cyc, hs, nbit, done_cnt, done_cyc, stall_cnt, idx, budget, post;
        logic prev_sclk, prev_bit, stall_act, sent_start, aborted;
        cyc = 0; hs = 0; nbit = 0; done_cnt = 0; done_cyc = -1; stall_cnt = 0; idx = 0;
        post = -1; prev_sclk = 1'b0; prev_bit = 1'b0; sent_start = 1'b0; aborted = 1'b0;
        budget = nbits * 4 + nbytes + stall_len + 40;

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (cyc < budget) begin
            stall_act = (idx == stall_byte) && (stall_cnt < stall_len);
            s_valid   = (idx < nbytes) && !stall_act;
            s_data    = (idx < 96) ? mem[idx] : 8'h00;
            @(negedge clk);
            if (cyc == 0) begin
                check("en_drop", int'(o_en), 0);
                check("busy_on", int'(o_busy), 1);
            end
            if (s_valid && o_ready) begin
                hs++;
                idx++;
            end
            if (stall_act && o_ready) begin
                stall_cnt++;
                check("stall_sclk", int'(o_sclk), 0);
                check("stall_bit", int'(o_bit), int'(prev_bit));
            end
            if (o_sclk && !prev_sclk) begin
                if (nbit < nbits) check("bit", int'(o_bit), int'(mem[nbit / 8][nbit % 8]));
                nbit++;
            end
            if (o_sclk && prev_sclk) check("hold", int'(o_bit), int'(prev_bit));
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (post < 0) post = 5;
            end
            prev_sclk = o_sclk;
            prev_bit  = o_bit;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (start_bits > 0 && nbit == start_bits && !sent_start) begin
                start      = 1'b1;
                sent_start = 1'b1;
            end
            if (abort_bits > 0 && nbit == abort_bits) begin
                s_valid = 1'b0;
                abort   = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                check("abort_busy", int'(o_busy), 0);
                check("abort_en",   int'(o_en),   0);
                check("abort_sclk", int'(o_sclk), 0);
                check("abort_bit",  int'(o_bit),  0);
                check("abort_done", int'(o_done), 0);
                aborted = 1'b1;
                break;
            end
            if (post > 0) post--;
            if (post == 0) break;
        end
        s_valid = 1'b0;

        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", int'(o_done), 0);
            end
            check("abort_done_cnt", done_cnt, 0);
            check("abort_bits_seen", nbit, abort_bits);
        end else begin
            check("handshakes", hs, nbytes);
            check("sclk_edges", nbit, nbits);
            check("done_count", done_cnt, 1);
            check("done_cycle", done_cyc, nbits * 4 + nbytes + stall_len);
            check("en_after", int'(o_en), 1);
            check("busy_after", int'(o_busy), 0);
        end
    endtask

    initial begin
        res_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00; sel = 1'b0;
        for (int i = 0; i < 96; i++) mem[i] = 8'(i);
        #23;
        res_n = 1'b1;

        // Idle after reset: nothing moves even with s_valid offered.
        s_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle_outputs("rst_big");
        end
        sel = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_small");
        s_valid = 1'b0;
        sel = 1'b0;

        // Full 736-bit load, bytes 0x00..0x5B, no stalls.
        run_load(736, 92, -1, 0, 0, 0);

        // Partial last byte: 12 bits from 0xA5, 0xFF.
        sel = 1'b1;
        mem[0] = 8'hA5;
        mem[1] = 8'hFF;
        run_load(12, 2, -1, 0, 0, 0);

        // Source stall of 20 cycles before the second byte.
        run_load(12, 2, 1, 20, 0, 0);

        // Abort after 100 bits, then a fresh full reload with a start pulse while busy.
        sel = 1'b0;
        for (int i = 0; i < 96; i++) mem[i] = 8'(i);
        run_load(736, 92, -1, 0, 100, 0);
        run_load(736, 92, -1, 0, 0, 50);

        // Asynchronous reset mid-shift.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hFF;
        repeat (60) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(o_busy), 1);
        res_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        res_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_ready", int'(o_ready), 0);
        end
        s_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
